// File: rtl/ex_bypass_scoreboard.sv
// ex_bypass_scoreboard: EX operand bypass network with per-register latency scoreboard and hazard stall
module ex_bypass_scoreboard #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int LAT_W  = 3,
  localparam int RW    = $clog2(NREG)
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [LANES*2*RW-1:0]         src_addr,
  input  logic [LANES*2-1:0]            src_used,
  input  logic [LANES*2*DATA_W-1:0]     rf_data,
  input  logic                          iss_fire,
  input  logic [LANES-1:0]              iss_wen,
  input  logic [LANES*RW-1:0]           iss_rd,
  input  logic [LANES*LAT_W-1:0]        iss_lat,
  input  logic                          pipe_adv,
  input  logic                          flush_all,
  input  logic [DEPTH*LANES-1:0]        byp_valid,
  input  logic [DEPTH*LANES*RW-1:0]     byp_rd,
  input  logic [DEPTH*LANES*DATA_W-1:0] byp_data,
  output logic [LANES*2*DATA_W-1:0]     opnd_data,
  output logic                          hazard_stall,
  output logic [NREG-1:0]               busy_mask,
  output logic [31:0]                   stall_cycles
);
  logic [LAT_W-1:0] cnt     [NREG];
  logic [LAT_W-1:0] cnt_nxt [NREG];
  // Operand select: oldest-priority entries are written first so the youngest stage / highest lane overrides
  always_comb begin
    opnd_data = rf_data;
    for (int i = 0; i < 2*LANES; i++) begin
      for (int st = DEPTH-1; st >= 0; st--)
        for (int ln = 0; ln < LANES; ln++)
          if (byp_valid[st*LANES+ln] && byp_rd[(st*LANES+ln)*RW +: RW] == src_addr[i*RW +: RW])
            opnd_data[i*DATA_W +: DATA_W] = byp_data[(st*LANES+ln)*DATA_W +: DATA_W];
      if (src_addr[i*RW +: RW] == '0) opnd_data[i*DATA_W +: DATA_W] = '0;
    end
  end
  // Stall on any pending source read or on a write that would be overtaken by an older slower producer
  always_comb begin
    hazard_stall = 1'b0;
    for (int i = 0; i < 2*LANES; i++)
      if (src_used[i] && src_addr[i*RW +: RW] != '0 && cnt[src_addr[i*RW +: RW]] != '0) hazard_stall = 1'b1;
    for (int l = 0; l < LANES; l++)
      if (iss_wen[l] && iss_rd[l*RW +: RW] != '0 && cnt[iss_rd[l*RW +: RW]] > iss_lat[l*LAT_W +: LAT_W]) hazard_stall = 1'b1;
  end
  // Next counter values: flush over issue load over decrement; later lanes override earlier ones on the same rd
  always_comb begin
    for (int r = 0; r < NREG; r++) cnt_nxt[r] = (pipe_adv && cnt[r] != '0) ? cnt[r] - LAT_W'(1) : cnt[r];
    if (iss_fire && !hazard_stall)
      for (int l = 0; l < LANES; l++)
        if (iss_wen[l] && iss_rd[l*RW +: RW] != '0) cnt_nxt[iss_rd[l*RW +: RW]] = iss_lat[l*LAT_W +: LAT_W];
    if (flush_all)
      for (int r = 0; r < NREG; r++) cnt_nxt[r] = '0;
  end
  // Scoreboard counters and their registered busy view
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      busy_mask <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r]       <= cnt_nxt[r];
        busy_mask[r] <= cnt_nxt[r] != '0;
      end
    end
  end
  // Saturating count of stalled cycles, cleared by flush
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) stall_cycles <= '0;
    else if (flush_all) stall_cycles <= '0;
    else if (hazard_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
endmodule

// File: doc/ex_bypass_scoreboard.md
Name: ex_bypass_scoreboard

Overview:
- Parametrised operand-bypass and hazard unit for the execute stage.
- Generalises the per-lane EX1 forwarding pair to LANES issue lanes and DEPTH bypass stages.
- Adds a per-register latency scoreboard, so multi-cycle producers (load, mul, div) stall consumers for exactly their remaining latency instead of a fixed "valid" guess.
- Sits between the issue/EX1 register and the ALU/branch/memory operand muxes; drives the EX1 forward_stall.

Parameters:
- LANES, 2, issue lanes.
- DEPTH, 2, bypass stages after EX1 (stage 0 = youngest, i.e. EX1/EX2).
- DATA_W, 32, operand width.
- NREG, 32, architectural registers; index width RW = clog2(NREG).
- LAT_W, 3, scoreboard latency counter width.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- src_addr  in  LANES*2*RW  {rk,rj} address per lane, lane 0 in the LSBs
- src_used  in  LANES*2  source actually read
- rf_data  in  LANES*2*DATA_W  register-file read data, same packing
- iss_fire  in  1  bundle leaves EX1 this cycle
- iss_wen  in  LANES  lane writes rd
- iss_rd  in  LANES*RW  destination per lane
- iss_lat  in  LANES*LAT_W  stall cycles before the result is visible on the bypass
- pipe_adv  in  1  downstream pipeline advances
- flush_all  in  1  exception/ertn commit flush
- byp_valid  in  DEPTH*LANES  bypass data valid
- byp_rd  in  DEPTH*LANES*RW  bypass destination
- byp_data  in  DEPTH*LANES*DATA_W  bypass data
- opnd_data  out  LANES*2*DATA_W  resolved operands
- hazard_stall  out  1  bundle must not issue
- busy_mask  out  NREG  registered: counter nonzero per register
- stall_cycles  out  32  registered count of cycles with hazard_stall=1

Behaviour:
- State is cnt[r] (LAT_W bits) per register r. Reset (asynchronous) and flush_all clear all cnt and stall_cycles to 0. busy_mask resets to 0; with zero counters hazard_stall evaluates to 0 and opnd_data falls back to rf_data.
- Register-update priority, highest first: flush_all > issue load > decrement.
- Issue load: when iss_fire and iss_wen[l] and iss_rd[l] != 0, cnt[iss_rd[l]] <= iss_lat[l] on the next edge.
- Same-rd conflict: if two lanes write the same rd, the highest lane wins.
- Decrement: on pipe_adv, every nonzero cnt not being loaded decrements by 1. It saturates at 0 and never wraps.
- Operand resolution (combinational) for source s of lane l, where a = src_addr:
  - a == 0 gives 0.
  - Otherwise scan stages 0..DEPTH-1 (younger first); within a stage scan lanes from highest to lowest. The first entry with byp_valid and byp_rd == a supplies byp_data.
  - If nothing matches, use rf_data.
- Per-source stall condition: src_used, a != 0, and cnt[a] != 0.
- WAW stall condition: iss_wen[l], rd != 0, and cnt[rd] > iss_lat[l]. This prevents an older slow result from overwriting a younger one.
- hazard_stall is the OR of all per-source stall conditions and WAW stall conditions over all lanes.
- iss_fire asserted while hazard_stall=1 is illegal and must be flagged by a bench assertion. The unit ignores the load in that case.
- Intra-bundle RAW (lane k reading lane j<k's rd) is excluded by the issue logic and is not checked here.
- busy_mask[r] <= (next cnt[r] != 0) every cycle.
- stall_cycles increments when hazard_stall; it saturates at 0xFFFFFFFF.
- Reset mid-operation: aresetn low immediately clears state regardless of clk. The first cycle after release behaves as post-reset.

Test Plan:
- Reset then no issue: src_addr r5 with rf_data 0x11 -> opnd 0x11, hazard_stall 0, busy_mask 0.
- Load latency: issue lane0 rd=r4, lat=2; next cycle lane1 reads r4 -> stall for 2 pipe_adv cycles, released on the 3rd cycle. With byp stage1 lane0 {valid,r4,0xDEAD}, opnd=0xDEAD.
- Priority: stage0 lane0 and stage1 lane1 both carry r7, data 0xA/0xB -> 0xA. Stage0 lanes 0 and 1 both carry r7, data 0xC/0xD -> 0xD.
- WAW: r3 loaded with lat=5, then an issue of rd=r3 with lat=1 -> hazard_stall=1 until cnt[r3] <= 1.
- Simultaneous events: issue lat=3 to r9 while pipe_adv with cnt[r9]=1 -> cnt[r9]=3. Both lanes write r9 with lat 1/4 -> cnt=4.
- Flush and r0: flush_all with several busy registers -> busy_mask 0 next cycle, stall released. Issue rd=r0 lat=7 -> no state change, r0 always reads 0.
